// File: rtl/sdr_bank_tracker.sv
// sdr_bank_tracker: passive SDRAM command-bus monitor.
// Tracks per-bank state and open row, flags tRCD/tRAS/tRP/tRFC violations.
module sdr_bank_tracker #(
    parameter int TRCD = 3,
    parameter int TRAS = 6,
    parameter int TRP  = 3,
    parameter int TRFC = 7
) (
    input  logic        sdram_clk,
    input  logic        sdram_resetn,
    input  logic        sdr_cke,
    input  logic        sdr_cs_n,
    input  logic        sdr_ras_n,
    input  logic        sdr_cas_n,
    input  logic        sdr_we_n,
    input  logic [1:0]  sdr_ba,
    input  logic [12:0] sdr_addr,
    output logic [11:0] bank_st,
    output logic [51:0] open_row,
    output logic        viol,
    output logic [2:0]  viol_code,
    output logic [1:0]  viol_bank,
    output logic [15:0] viol_cnt
);

    localparam int CW = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_PRE  = 3'b001,
        ST_ACT  = 3'b010,
        ST_XFR  = 3'b011
    } bank_state_t;

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_t;

    typedef enum logic [2:0] {
        V_NONE     = 3'd0,
        V_RW_IDLE  = 3'd1,
        V_TRCD     = 3'd2,
        V_TRAS     = 3'd3,
        V_ACT_OPEN = 3'd4,
        V_TRP      = 3'd5,
        V_REF_OPEN = 3'd6,
        V_TRFC     = 3'd7
    } viol_t;

    bank_state_t   st_q  [4];
    bank_state_t   st_d  [4];
    logic [12:0]   row_q [4];
    logic [12:0]   row_d [4];
    logic [CW-1:0] rcd_q [4];
    logic [CW-1:0] rcd_d [4];
    logic [CW-1:0] ras_q [4];
    logic [CW-1:0] ras_d [4];
    logic [CW-1:0] rp_q  [4];
    logic [CW-1:0] rp_d  [4];
    logic [CW-1:0] rfc_q;
    logic [CW-1:0] rfc_d;
    viol_t         bcode [4];

    cmd_t          cmd;
    logic          is_rw;
    logic          any_open;
    logic [1:0]    low_open;
    logic          v_d;
    viol_t         code_d;
    logic [1:0]    bank_d;

    function automatic logic [CW-1:0] dec(input logic [CW-1:0] c);
        return (c == '0) ? '0 : c - CW'(1);
    endfunction

    always_comb begin
        cmd = CMD_NOP;
        if (sdr_cke && !sdr_cs_n) begin
            cmd = cmd_t'({sdr_ras_n, sdr_cas_n, sdr_we_n});
        end
        is_rw = (cmd == CMD_RD) || (cmd == CMD_WR);
    end

    always_comb begin
        any_open = 1'b0;
        low_open = '0;
        for (int b = 3; b >= 0; b--) begin
            if (st_q[b] != ST_IDLE) begin
                any_open = 1'b1;
                low_open = 2'(b);
            end
        end
    end

    always_comb begin
        st_d   = st_q;
        row_d  = row_q;
        rfc_d  = dec(rfc_q);
        v_d    = 1'b0;
        code_d = V_NONE;
        bank_d = '0;
        for (int b = 0; b < 4; b++) begin
            rcd_d[b] = dec(rcd_q[b]);
            ras_d[b] = dec(ras_q[b]);
            rp_d[b]  = dec(rp_q[b]);
            bcode[b] = V_NONE;
            // Precharge completes on the edge where rp samples zero.
            if (st_q[b] == ST_PRE && rp_q[b] == '0) begin
                st_d[b] = ST_IDLE;
            end
        end
        if (cmd != CMD_NOP) begin
            if (rfc_q != '0) begin
                v_d    = 1'b1;
                code_d = V_TRFC;
                bank_d = sdr_ba;
            end else if (cmd == CMD_REF || cmd == CMD_LMR) begin
                if (any_open) begin
                    v_d    = 1'b1;
                    code_d = V_REF_OPEN;
                    bank_d = low_open;
                end else if (cmd == CMD_REF) begin
                    rfc_d = CW'(TRFC - 1);
                end
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (sdr_ba == 2'(b) ||
                        (cmd == CMD_PRE && sdr_addr[10])) begin
                        unique case (st_q[b])
                            ST_IDLE: begin
                                if (cmd == CMD_ACT) begin
                                    st_d[b]  = ST_ACT;
                                    row_d[b] = sdr_addr;
                                    rcd_d[b] = CW'(TRCD - 1);
                                    ras_d[b] = CW'(TRAS - 1);
                                end else if (is_rw) begin
                                    bcode[b] = V_RW_IDLE;
                                end
                            end
                            ST_ACT, ST_XFR: begin
                                if (is_rw) begin
                                    if (st_q[b] == ST_ACT &&
                                        rcd_q[b] != '0) begin
                                        bcode[b] = V_TRCD;
                                    end else begin
                                        st_d[b] = ST_XFR;
                                    end
                                end else if (cmd == CMD_PRE) begin
                                    st_d[b] = ST_PRE;
                                    rp_d[b] = CW'(TRP - 1);
                                    if (ras_q[b] != '0) begin
                                        bcode[b] = V_TRAS;
                                    end
                                end else if (cmd == CMD_ACT) begin
                                    bcode[b] = V_ACT_OPEN;
                                end else if (cmd == CMD_BST &&
                                             st_q[b] == ST_XFR) begin
                                    st_d[b] = ST_ACT;
                                end
                            end
                            ST_PRE: begin
                                if (rp_q[b] != '0) begin
                                    if (cmd == CMD_ACT || is_rw) begin
                                        bcode[b] = V_TRP;
                                    end
                                end else if (cmd == CMD_ACT) begin
                                    st_d[b]  = ST_ACT;
                                    row_d[b] = sdr_addr;
                                    rcd_d[b] = CW'(TRCD - 1);
                                    ras_d[b] = CW'(TRAS - 1);
                                end else if (is_rw) begin
                                    bcode[b] = V_RW_IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                // Lowest-numbered offending bank wins.
                for (int b = 3; b >= 0; b--) begin
                    if (bcode[b] != V_NONE) begin
                        v_d    = 1'b1;
                        code_d = bcode[b];
                        bank_d = 2'(b);
                    end
                end
            end
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            for (int b = 0; b < 4; b++) begin
                st_q[b]  <= ST_IDLE;
                row_q[b] <= '0;
                rcd_q[b] <= '0;
                ras_q[b] <= '0;
                rp_q[b]  <= '0;
            end
            rfc_q     <= '0;
            viol      <= 1'b0;
            viol_code <= '0;
            viol_bank <= '0;
            viol_cnt  <= '0;
        end else begin
            st_q  <= st_d;
            row_q <= row_d;
            rcd_q <= rcd_d;
            ras_q <= ras_d;
            rp_q  <= rp_d;
            rfc_q <= rfc_d;
            viol  <= v_d;
            if (v_d) begin
                viol_code <= code_d;
                viol_bank <= bank_d;
                if (viol_cnt != 16'hFFFF) begin
                    viol_cnt <= viol_cnt + 16'd1;
                end
            end
        end
    end

    always_comb begin
        bank_st  = '0;
        open_row = '0;
        for (int b = 0; b < 4; b++) begin
            bank_st[3*b +: 3]   = st_q[b];
            open_row[13*b +: 13] = row_q[b];
        end
    end

endmodule
